// File: rtl/tse_tx_packet_buffer.sv
// tse_tx_packet_buffer: store-and-forward TX packet FIFO between tse_controller and the TSE MAC.
// Only complete packets become visible to the read side; overflowing or malformed packets are dropped.
//
// Write FSM states
//   state   | meaning
//   WR_IDLE | between packets, beats without sop are discarded
//   WR_RECV | packet in progress, beats written speculatively past wr_commit
//   WR_DROP | packet being discarded until its eop (or a new sop)
module tse_tx_packet_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 16,
    localparam int EMPTY_WIDTH = $clog2(DATA_WIDTH / 8)
) (
    input  logic                   Clock_xCI,
    input  logic                   Reset_xSI,
    input  logic [DATA_WIDTH-1:0]  Sink_Data_xDI,
    input  logic                   Sink_Valid_xSI,
    input  logic                   Sink_Sop_xSI,
    input  logic                   Sink_Eop_xSI,
    input  logic [EMPTY_WIDTH-1:0] Sink_Empty_xDI,
    output logic                   Sink_Ready_xSO,
    output logic [DATA_WIDTH-1:0]  Source_Data_xDO,
    output logic                   Source_Valid_xSO,
    output logic                   Source_Sop_xSO,
    output logic                   Source_Eop_xSO,
    output logic [EMPTY_WIDTH-1:0] Source_Empty_xDO,
    input  logic                   Source_Ready_xSI,
    output logic [CNT_WIDTH-1:0]   Pkt_Count_xDO,
    output logic [CNT_WIDTH-1:0]   Drop_Count_xDO,
    output logic                   Overflow_xSO
);

    localparam int WORD_WIDTH = 1 + EMPTY_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] FULL_GAP = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {WR_IDLE, WR_RECV, WR_DROP} wr_state_t;

    wr_state_t wr_state, wr_state_nxt;
    logic [ADDR_WIDTH:0] wr_ptr, wr_ptr_nxt, wr_commit, wr_commit_nxt, rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic wr_en, commit, sink_acc, cur_full, base_full;
    logic [1:0] drop_amt;
    logic [CNT_WIDTH:0] drop_sum;

    logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [WORD_WIDTH-1:0] ram_q;
    logic s1_valid, rd_en, out_load, src_acc, pkt_dec, first_beat;
    logic ram_eop;
    logic [EMPTY_WIDTH-1:0] ram_empty;

    assign sink_acc  = Sink_Valid_xSI & Sink_Ready_xSO;
    assign cur_full  = (wr_ptr - rd_ptr) == FULL_GAP;
    assign base_full = (wr_commit - rd_ptr) == FULL_GAP;
    assign drop_sum  = {1'b0, Drop_Count_xDO} + {{(CNT_WIDTH-1){1'b0}}, drop_amt};

    // Write FSM next state, RAM write strobe, commit and drop events
    always_comb begin
        wr_state_nxt  = wr_state;
        wr_ptr_nxt    = wr_ptr;
        wr_commit_nxt = wr_commit;
        wr_addr       = wr_ptr[ADDR_WIDTH-1:0];
        wr_en         = 1'b0;
        commit        = 1'b0;
        drop_amt      = 2'd0;
        if (sink_acc) begin
            if (Sink_Sop_xSI) begin
                // a new sop always restarts at the last committed position
                if (wr_state == WR_RECV) drop_amt = 2'd1;
                wr_ptr_nxt = wr_commit;
                if (base_full) begin
                    drop_amt     = drop_amt + 2'd1;
                    wr_state_nxt = Sink_Eop_xSI ? WR_IDLE : WR_DROP;
                end else begin
                    wr_en      = 1'b1;
                    wr_addr    = wr_commit[ADDR_WIDTH-1:0];
                    wr_ptr_nxt = wr_commit + PTR_ONE;
                    if (Sink_Eop_xSI) begin
                        wr_commit_nxt = wr_commit + PTR_ONE;
                        commit        = 1'b1;
                        wr_state_nxt  = WR_IDLE;
                    end else begin
                        wr_state_nxt = WR_RECV;
                    end
                end
            end else begin
                case (wr_state)
                    WR_RECV: begin
                        if (cur_full) begin
                            wr_ptr_nxt   = wr_commit;
                            drop_amt     = 2'd1;
                            wr_state_nxt = Sink_Eop_xSI ? WR_IDLE : WR_DROP;
                        end else begin
                            wr_en      = 1'b1;
                            wr_ptr_nxt = wr_ptr + PTR_ONE;
                            if (Sink_Eop_xSI) begin
                                wr_commit_nxt = wr_ptr + PTR_ONE;
                                commit        = 1'b1;
                                wr_state_nxt  = WR_IDLE;
                            end
                        end
                    end
                    WR_DROP: begin
                        if (Sink_Eop_xSI) wr_state_nxt = WR_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Write-side state, pointers and counters
    always_ff @(posedge Clock_xCI) begin
        if (Reset_xSI) begin
            wr_state       <= WR_IDLE;
            wr_ptr         <= '0;
            wr_commit      <= '0;
            Sink_Ready_xSO <= 1'b0;
            Pkt_Count_xDO  <= '0;
            Drop_Count_xDO <= '0;
            Overflow_xSO   <= 1'b0;
        end else begin
            wr_state       <= wr_state_nxt;
            wr_ptr         <= wr_ptr_nxt;
            wr_commit      <= wr_commit_nxt;
            Sink_Ready_xSO <= 1'b1;
            Overflow_xSO   <= (drop_amt != 2'd0);
            Drop_Count_xDO <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
            case ({commit, pkt_dec})
                2'b10:   Pkt_Count_xDO <= Pkt_Count_xDO + CNT_ONE;
                2'b01:   Pkt_Count_xDO <= Pkt_Count_xDO - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Packet RAM: word = {eop, empty, data}
    always_ff @(posedge Clock_xCI) begin
        if (wr_en) mem[wr_addr] <= {Sink_Eop_xSI, Sink_Empty_xDI, Sink_Data_xDI};
        if (rd_en) ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end

    // Read side: only committed words are fetched; s1 is the RAM output stage
    assign src_acc   = Source_Valid_xSO & Source_Ready_xSI;
    assign pkt_dec   = src_acc & Source_Eop_xSO;
    assign out_load  = ~Source_Valid_xSO | Source_Ready_xSI;
    assign rd_en     = (rd_ptr != wr_commit) & (~s1_valid | out_load);
    assign ram_eop   = ram_q[WORD_WIDTH-1];
    assign ram_empty = ram_q[DATA_WIDTH +: EMPTY_WIDTH];

    // Read pointer and RAM-output valid flag
    always_ff @(posedge Clock_xCI) begin
        if (Reset_xSI) begin
            rd_ptr   <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            if (rd_en) s1_valid <= 1'b1;
            else if (out_load) s1_valid <= 1'b0;
        end
    end

    // Output register: holds while stalled, sop regenerated after each eop
    always_ff @(posedge Clock_xCI) begin
        if (Reset_xSI) begin
            Source_Valid_xSO <= 1'b0;
            Source_Data_xDO  <= '0;
            Source_Sop_xSO   <= 1'b0;
            Source_Eop_xSO   <= 1'b0;
            Source_Empty_xDO <= '0;
            first_beat       <= 1'b1;
        end else if (out_load) begin
            Source_Valid_xSO <= s1_valid;
            if (s1_valid) begin
                Source_Data_xDO  <= ram_q[DATA_WIDTH-1:0];
                Source_Sop_xSO   <= first_beat;
                Source_Eop_xSO   <= ram_eop;
                Source_Empty_xDO <= ram_eop ? ram_empty : '0;
                first_beat       <= ram_eop;
            end else begin
                Source_Data_xDO  <= '0;
                Source_Sop_xSO   <= 1'b0;
                Source_Eop_xSO   <= 1'b0;
                Source_Empty_xDO <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tse_tx_packet_buffer.sv
// Testbench for tse_tx_packet_buffer: directed scenarios plus randomized packets against a queue model.
module tb_tse_tx_packet_buffer;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = 16;
    localparam int EW    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          Reset_xSI;
    logic [DW-1:0] Sink_Data_xDI;
    logic          Sink_Valid_xSI, Sink_Sop_xSI, Sink_Eop_xSI, Sink_Ready_xSO;
    logic [EW-1:0] Sink_Empty_xDI;
    logic [DW-1:0] Source_Data_xDO;
    logic          Source_Valid_xSO, Source_Sop_xSO, Source_Eop_xSO, Source_Ready_xSI;
    logic [EW-1:0] Source_Empty_xDO;
    logic [CW-1:0] Pkt_Count_xDO, Drop_Count_xDO;
    logic          Overflow_xSO;

    tse_tx_packet_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .Clock_xCI(clk), .Reset_xSI(Reset_xSI),
        .Sink_Data_xDI(Sink_Data_xDI), .Sink_Valid_xSI(Sink_Valid_xSI),
        .Sink_Sop_xSI(Sink_Sop_xSI), .Sink_Eop_xSI(Sink_Eop_xSI),
        .Sink_Empty_xDI(Sink_Empty_xDI), .Sink_Ready_xSO(Sink_Ready_xSO),
        .Source_Data_xDO(Source_Data_xDO), .Source_Valid_xSO(Source_Valid_xSO),
        .Source_Sop_xSO(Source_Sop_xSO), .Source_Eop_xSO(Source_Eop_xSO),
        .Source_Empty_xDO(Source_Empty_xDO), .Source_Ready_xSI(Source_Ready_xSI),
        .Pkt_Count_xDO(Pkt_Count_xDO), .Drop_Count_xDO(Drop_Count_xDO),
        .Overflow_xSO(Overflow_xSO)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    beat_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int exp_drop = 0;
    int n_ovf = 0;
    int n_out = 0;
    int cyc = 0;
    int last_xfer_cyc = 0;
    int ready_mode = 0;
    bit gaps_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Source ready pattern: 0 hold low, 1 hold high, 2 toggle, 3 random
    initial begin
        Source_Ready_xSI = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       Source_Ready_xSI = 1'b0;
                1:       Source_Ready_xSI = 1'b1;
                2:       Source_Ready_xSI = ~Source_Ready_xSI;
                default: Source_Ready_xSI = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: compares transfers against the model queue, checks stall stability
    beat_t held;
    bit    hold_v = 1'b0;
    always @(negedge clk) begin
        beat_t b;
        cyc++;
        if (Reset_xSI) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", Source_Valid_xSO, 1);
                chk("hold_data", Source_Data_xDO, held.data);
                chk("hold_flags", {Source_Sop_xSO, Source_Eop_xSO, Source_Empty_xDO},
                    {held.sop, held.eop, held.empty});
            end
            if (Source_Valid_xSO && Source_Ready_xSI) begin
                hold_v = 1'b0;
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    chk("out_data", Source_Data_xDO, b.data);
                    chk("out_sop", Source_Sop_xSO, b.sop);
                    chk("out_eop", Source_Eop_xSO, b.eop);
                    chk("out_empty", Source_Empty_xDO, b.empty);
                end
                n_out++;
                last_xfer_cyc = cyc;
            end else if (Source_Valid_xSO) begin
                hold_v     = 1'b1;
                held.data  = Source_Data_xDO;
                held.sop   = Source_Sop_xSO;
                held.eop   = Source_Eop_xSO;
                held.empty = Source_Empty_xDO;
            end else begin
                hold_v = 1'b0;
            end
            if (Overflow_xSO) n_ovf++;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e, input logic [EW-1:0] em);
        if (gaps_en && $urandom_range(0, 3) == 0) begin
            Sink_Valid_xSI = 1'b0;
            @(posedge clk); #1;
        end
        Sink_Valid_xSI = 1'b1;
        Sink_Data_xDI  = d;
        Sink_Sop_xSI   = s;
        Sink_Eop_xSI   = e;
        Sink_Empty_xDI = em;
        @(posedge clk); #1;
        Sink_Valid_xSI = 1'b0;
    endtask

    // Complete packet into a drained buffer: delivered if it fits, otherwise one drop
    task automatic send_pkt(input int len, input logic [DW-1:0] base, input logic [EW-1:0] last_empty, input bit rnd);
        logic [DW-1:0] d[$];
        beat_t b;
        for (int i = 0; i < len; i++) d.push_back(rnd ? DW'($urandom) : base + DW'(i));
        if (len <= DEPTH) begin
            for (int i = 0; i < len; i++) begin
                b.data  = d[i];
                b.sop   = (i == 0);
                b.eop   = (i == len - 1);
                b.empty = (i == len - 1) ? last_empty : '0;
                exp_q.push_back(b);
            end
        end else begin
            exp_drop++;
        end
        for (int i = 0; i < len; i++)
            send_beat(d[i], i == 0, i == len - 1, (i == len - 1) ? last_empty : EW'($urandom));
    endtask

    // Unterminated packet; the next sop makes it a drop
    task automatic send_partial(input int len);
        exp_drop++;
        for (int i = 0; i < len; i++) send_beat(DW'($urandom), i == 0, 1'b0, EW'($urandom));
    endtask

    task automatic send_stray(input int len);
        for (int i = 0; i < len; i++)
            send_beat(DW'($urandom), 1'b0, 1'($urandom_range(0, 1)), EW'($urandom));
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || Source_Valid_xSO || Pkt_Count_xDO != 0) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_pkt_count", Pkt_Count_xDO, 0);
    endtask

    task automatic wait_nout(input int target, input int limit);
        int n = 0;
        while (n_out < target && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_out", n_out >= target, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, vcount, c_first, kind;
        Reset_xSI      = 1'b1;
        Sink_Valid_xSI = 1'b0;
        Sink_Data_xDI  = '0;
        Sink_Sop_xSI   = 1'b0;
        Sink_Eop_xSI   = 1'b0;
        Sink_Empty_xDI = '0;

        // reset values
        tick(1);
        chk("rst_sink_ready", Sink_Ready_xSO, 0);
        chk("rst_src_valid", Source_Valid_xSO, 0);
        chk("rst_pkt_count", Pkt_Count_xDO, 0);
        chk("rst_drop_count", Drop_Count_xDO, 0);
        chk("rst_overflow", Overflow_xSO, 0);
        tick(1);
        Reset_xSI = 1'b0;
        tick(1);
        chk("post_rst_sink_ready", Sink_Ready_xSO, 1);
        chk("post_rst_src_data", {Source_Data_xDO, Source_Sop_xSO, Source_Eop_xSO, Source_Empty_xDO}, 0);

        // 1: single 6-beat packet and latency
        ready_mode = 1;
        tick(2);
        send_pkt(6, 32'hadd00000, 2'd2, 1'b0);
        chk("t1_pkt_count", Pkt_Count_xDO, 1);
        tick(1);
        chk("t1_latency_k1", Source_Valid_xSO, 0);
        tick(1);
        chk("t1_latency_k2", Source_Valid_xSO, 1);
        chk("t1_first_sop", Source_Sop_xSO, 1);
        wait_drain(100);

        // 2: 16-beat packet with ready toggling
        ready_mode = 2;
        send_pkt(16, 32'h16000000, 2'd1, 1'b0);
        wait_drain(200);

        // 3: oversize packet with ready low, then a small packet
        ready_mode = 0;
        send_pkt(DEPTH + 4, 32'h30000000, 2'd3, 1'b0);
        tick(2);
        chk("t3_drop_count", Drop_Count_xDO, 1);
        chk("t3_overflow_pulses", n_ovf, 1);
        chk("t3_pkt_count", Pkt_Count_xDO, 0);
        chk("t3_sink_ready", Sink_Ready_xSO, 1);
        send_pkt(4, 32'h34000000, 2'd0, 1'b0);
        tick(2);
        chk("t3_pkt_count_after", Pkt_Count_xDO, 1);
        ready_mode = 1;
        wait_drain(100);

        // 4: sop inside an unfinished packet, then stray beats in idle
        send_partial(3);
        send_pkt(4, 32'h40000000, 2'd1, 1'b0);
        send_stray(3);
        wait_drain(100);
        chk("t4_drop_count", Drop_Count_xDO, exp_drop);

        // 5: three back-to-back packets held, then streamed
        ready_mode = 0;
        send_pkt(1, 32'h50000000, 2'd3, 1'b0);
        send_pkt(5, 32'h51000000, 2'd2, 1'b0);
        send_pkt(16, 32'h52000000, 2'd1, 1'b0);
        tick(3);
        chk("t5_pkt_count_peak", Pkt_Count_xDO, 3);
        n0 = n_out;
        ready_mode = 1;
        wait_nout(n0 + 1, 50);
        c_first = last_xfer_cyc;
        wait_nout(n0 + 22, 100);
        chk("t5_contiguous", last_xfer_cyc - c_first, 21);
        wait_drain(100);

        // 6: reset in the middle of output
        n0 = n_out;
        send_pkt(10, 32'h60000000, 2'd2, 1'b0);
        wait_nout(n0 + 3, 50);
        Reset_xSI = 1'b1;
        exp_q.delete();
        exp_drop = 0;
        n_ovf = 0;
        tick(1);
        chk("t6_valid_after_reset", Source_Valid_xSO, 0);
        chk("t6_pkt_count", Pkt_Count_xDO, 0);
        chk("t6_drop_count", Drop_Count_xDO, 0);
        tick(1);
        Reset_xSI = 1'b0;
        n0 = n_out;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (Source_Valid_xSO) vcount++;
        end
        chk("t6_no_residual_valid", vcount, 0);
        chk("t6_no_residual_beats", n_out - n0, 0);

        // randomized packets, gaps and back-pressure
        gaps_en = 1'b1;
        ready_mode = 3;
        for (int p = 0; p < 40; p++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                send_pkt($urandom_range(1, DEPTH), '0, EW'($urandom), 1'b1);
            end else if (kind == 6) begin
                send_pkt($urandom_range(DEPTH + 1, DEPTH + 6), '0, EW'($urandom), 1'b1);
            end else if (kind == 7) begin
                send_partial($urandom_range(1, 4));
                send_pkt($urandom_range(1, DEPTH), '0, EW'($urandom), 1'b1);
            end else begin
                send_stray($urandom_range(1, 3));
            end
            wait_drain(1000);
        end
        tick(2);
        chk("final_drop_count", Drop_Count_xDO, exp_drop);
        chk("final_overflow_pulses", n_ovf, exp_drop);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
